// File: rtl/layer_compositor_if.sv
// layer_compositor_if: pixel-side inputs and composited/overlap outputs of the layer compositor
// Signals: frame_start, pix_valid, layer_en, layer_mask, layer_rgb, bg_rgb (source -> compositor)
//          out_valid, out_rgb, out_layer, col_frame, hit_cnt, col_strobe (compositor -> sink)
// Modports: master = pixel source / result consumer, slave = compositor
interface layer_compositor_if #(
    parameter int NUM_LAYERS = 6,
    parameter int RGB_W = 12,
    parameter int CNT_W = 16
);
    localparam int LIDX_W = $clog2(NUM_LAYERS + 1);
    logic frame_start;
    logic pix_valid;
    logic [NUM_LAYERS-1:0] layer_en;
    logic [NUM_LAYERS-1:0] layer_mask;
    logic [NUM_LAYERS*RGB_W-1:0] layer_rgb;
    logic [RGB_W-1:0] bg_rgb;
    logic out_valid;
    logic [RGB_W-1:0] out_rgb;
    logic [LIDX_W-1:0] out_layer;
    logic [NUM_LAYERS-1:0] col_frame;
    logic [CNT_W-1:0] hit_cnt;
    logic col_strobe;
    modport master (
        output frame_start, pix_valid, layer_en, layer_mask, layer_rgb, bg_rgb,
        input out_valid, out_rgb, out_layer, col_frame, hit_cnt, col_strobe
    );
    modport slave (
        input frame_start, pix_valid, layer_en, layer_mask, layer_rgb, bg_rgb,
        output out_valid, out_rgb, out_layer, col_frame, hit_cnt, col_strobe
    );
endinterface

// File: rtl/layer_compositor.sv
// layer_compositor: two-stage priority compositor of sprite layers over a background with per-frame overlap detection
// Ports: clk pixel clock; rst synchronous active-low reset;
//        bus (slave) carries pixel inputs and the composited colour/layer plus overlap report
module layer_compositor #(
    parameter int NUM_LAYERS = 6,
    parameter int RGB_W = 12,
    parameter logic [RGB_W-1:0] KEY_COLOR = '0,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst,
    layer_compositor_if.slave bus
);
    localparam int LIDX_W = $clog2(NUM_LAYERS + 1);
    logic [NUM_LAYERS-1:0] opq_in, opq, sticky, sticky_nxt;
    logic [NUM_LAYERS*RGB_W-1:0] rgb;
    logic [RGB_W-1:0] bg, win_rgb;
    logic [LIDX_W-1:0] win_idx;
    logic valid, hit;
    logic [CNT_W-1:0] run_cnt, cnt_nxt;
    always_comb begin
        opq_in = '0;
        for (int i = 0; i < NUM_LAYERS; i++)
            opq_in[i] = bus.layer_en[i] & bus.layer_mask[i] & (bus.layer_rgb[i*RGB_W +: RGB_W] != KEY_COLOR);
    end
    // scanning downward leaves the lowest opaque index as the winner
    always_comb begin
        win_rgb = bg;
        win_idx = LIDX_W'(NUM_LAYERS);
        for (int i = NUM_LAYERS - 1; i >= 0; i--)
            if (opq[i]) begin
                win_rgb = rgb[i*RGB_W +: RGB_W];
                win_idx = LIDX_W'(i);
            end
    end
    assign hit = valid && ($countones(opq) >= 2);
    assign sticky_nxt = hit ? sticky | opq : sticky;
    assign cnt_nxt = (hit && run_cnt != '1) ? run_cnt + 1'b1 : run_cnt;
    always_ff @(posedge clk) begin
        if (!rst) begin
            opq <= '0;
            rgb <= '0;
            bg <= '0;
            valid <= 1'b0;
            sticky <= '0;
            run_cnt <= '0;
            bus.out_valid <= 1'b0;
            bus.out_rgb <= '0;
            bus.out_layer <= '0;
            bus.col_frame <= '0;
            bus.hit_cnt <= '0;
            bus.col_strobe <= 1'b0;
        end else begin
            opq <= opq_in;
            rgb <= bus.layer_rgb;
            bg <= bus.bg_rgb;
            valid <= bus.pix_valid;
            bus.out_valid <= valid;
            bus.out_rgb <= valid ? win_rgb : '0;
            bus.out_layer <= valid ? win_idx : LIDX_W'(NUM_LAYERS);
            bus.col_strobe <= bus.frame_start;
            // the pixel sitting in stage 1 at frame_start still belongs to the closing frame
            if (bus.frame_start) begin
                bus.col_frame <= sticky_nxt;
                bus.hit_cnt <= cnt_nxt;
                sticky <= '0;
                run_cnt <= '0;
            end else begin
                sticky <= sticky_nxt;
                run_cnt <= cnt_nxt;
            end
        end
    end
endmodule

// File: tb/tb_layer_compositor.sv
// tb_layer_compositor: directed and randomized check of layer_compositor against a per-pixel/per-frame model
module tb_layer_compositor;
    localparam int NL = 6;
    localparam int CW = 4;
    localparam logic [11:0] KEY = 12'h000;
    logic clk = 1'b0;
    logic rst = 1'b0;
    layer_compositor_if #(.NUM_LAYERS(NL), .RGB_W(12), .CNT_W(CW)) bus();
    layer_compositor #(.NUM_LAYERS(NL), .RGB_W(12), .KEY_COLOR(KEY), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [11:0] rgb [NL];
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, got, exp);
        end
    endtask
    task automatic put(input bit v, input logic [NL-1:0] en, input logic [NL-1:0] mask,
                       input logic [11:0] bg, input bit fs);
        bus.pix_valid = v;
        bus.layer_en = en;
        bus.layer_mask = mask;
        bus.bg_rgb = bg;
        bus.frame_start = fs;
        for (int i = 0; i < NL; i++) bus.layer_rgb[i*12 +: 12] = rgb[i];
    endtask
    task automatic tick();
        @(negedge clk);
    endtask
    // Model: the pixel accepted at the previous edge is composited and scored at this edge.
    bit chk_on = 0;
    bit p_valid = 0;
    logic [NL-1:0] p_opq = '0;
    logic [11:0] p_rgb = '0;
    logic [2:0] p_layer = '0;
    bit e_valid = 0, e_strobe = 0;
    logic [11:0] e_rgb = '0;
    logic [2:0] e_layer = '0;
    logic [NL-1:0] e_frame = '0, acc_mask = '0;
    int acc_cnt = 0, e_cnt = 0, c;
    bit hit;
    always @(posedge clk) begin
        cyc++;
        chk_on = 1;
        if (!rst) begin
            e_valid = 0; e_rgb = 0; e_layer = 0; e_frame = 0; e_cnt = 0; e_strobe = 0;
            acc_mask = 0; acc_cnt = 0; p_valid = 0;
        end else begin
            e_valid = p_valid;
            e_rgb = p_valid ? p_rgb : 12'h000;
            e_layer = p_valid ? p_layer : 3'(NL);
            hit = p_valid && ($countones(p_opq) >= 2);
            c = acc_cnt + (hit ? 1 : 0);
            if (c > (1 << CW) - 1) c = (1 << CW) - 1;
            e_strobe = bus.frame_start;
            if (bus.frame_start) begin
                e_frame = acc_mask | (hit ? p_opq : '0);
                e_cnt = c;
                acc_mask = 0;
                acc_cnt = 0;
            end else begin
                acc_mask = acc_mask | (hit ? p_opq : '0);
                acc_cnt = c;
            end
            p_valid = bus.pix_valid;
            p_opq = '0;
            for (int i = 0; i < NL; i++)
                p_opq[i] = bus.layer_en[i] && bus.layer_mask[i] && (bus.layer_rgb[i*12 +: 12] != KEY);
            p_rgb = bus.bg_rgb;
            p_layer = 3'(NL);
            for (int i = 0; i < NL; i++)
                if (p_opq[i] && p_layer == 3'(NL)) begin
                    p_rgb = bus.layer_rgb[i*12 +: 12];
                    p_layer = 3'(i);
                end
        end
    end
    always @(negedge clk) begin
        if (chk_on) begin
            chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
            chk("out_rgb", 32'(bus.out_rgb), 32'(e_rgb));
            chk("out_layer", 32'(bus.out_layer), 32'(e_layer));
            chk("col_frame", 32'(bus.col_frame), 32'(e_frame));
            chk("hit_cnt", 32'(bus.hit_cnt), 32'(e_cnt));
            chk("col_strobe", 32'(bus.col_strobe), 32'(e_strobe));
        end
    end
    initial begin
        for (int i = 0; i < NL; i++) rgb[i] = 12'h000;
        put(0, '0, '1, 12'h000, 0);
        rst = 0;
        repeat (3) tick();
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_rgb", 32'(bus.out_rgb), 0);
        chk("rst_layer", 32'(bus.out_layer), 0);
        chk("rst_frame", 32'(bus.col_frame), 0);
        chk("rst_cnt", 32'(bus.hit_cnt), 0);
        chk("rst_strobe", 32'(bus.col_strobe), 0);
        rst = 1;
        rgb[2] = 12'hF00; rgb[3] = 12'h0F0;
        put(1, 6'b001100, '1, 12'h000, 0); tick();
        put(1, 6'b000000, '1, 12'h123, 0); tick();
        chk("prio_rgb", 32'(bus.out_rgb), 32'h F00);
        chk("prio_layer", 32'(bus.out_layer), 2);
        rgb[0] = KEY; rgb[1] = 12'hABC;
        put(1, 6'b000011, '1, 12'h456, 0); tick();
        chk("bg_rgb", 32'(bus.out_rgb), 32'h123);
        chk("bg_layer", 32'(bus.out_layer), 6);
        put(1, 6'b000011, 6'b111101, 12'h456, 0); tick();
        chk("key_rgb", 32'(bus.out_rgb), 32'hABC);
        chk("key_layer", 32'(bus.out_layer), 1);
        put(0, '0, '1, 12'h000, 1); tick();
        chk("mask_rgb", 32'(bus.out_rgb), 32'h456);
        chk("mask_layer", 32'(bus.out_layer), 6);
        chk("f0_frame", 32'(bus.col_frame), 32'b001100);
        chk("f0_cnt", 32'(bus.hit_cnt), 1);
        rgb[0] = 12'h111; rgb[2] = 12'h222;
        repeat (5) begin put(1, 6'b000101, '1, 12'h000, 0); tick(); end
        put(0, '0, '1, 12'h000, 1); tick();
        chk("col_strobe", 32'(bus.col_strobe), 1);
        chk("col_frame", 32'(bus.col_frame), 32'b000101);
        chk("col_cnt", 32'(bus.hit_cnt), 5);
        put(0, '0, '1, 12'h000, 0); tick();
        chk("hold_strobe", 32'(bus.col_strobe), 0);
        chk("hold_cnt", 32'(bus.hit_cnt), 5);
        put(0, '0, '1, 12'h000, 1); tick();
        chk("empty_strobe", 32'(bus.col_strobe), 1);
        chk("empty_frame", 32'(bus.col_frame), 0);
        chk("empty_cnt", 32'(bus.hit_cnt), 0);
        repeat (2) begin put(1, 6'b000101, '1, 12'h000, 0); tick(); end
        put(0, '0, '1, 12'h000, 1); tick();
        chk("dbl1_cnt", 32'(bus.hit_cnt), 2);
        put(0, '0, '1, 12'h000, 1); tick();
        chk("dbl2_strobe", 32'(bus.col_strobe), 1);
        chk("dbl2_cnt", 32'(bus.hit_cnt), 0);
        rgb[1] = 12'h222;
        put(0, 6'b000011, '1, 12'h000, 0); tick();
        put(0, '0, '1, 12'h000, 1); tick();
        chk("blank_valid", 32'(bus.out_valid), 0);
        chk("blank_rgb", 32'(bus.out_rgb), 0);
        chk("blank_cnt", 32'(bus.hit_cnt), 0);
        repeat (20) begin put(1, 6'b000011, '1, 12'h000, 0); tick(); end
        put(0, '0, '1, 12'h000, 1); tick();
        chk("sat_cnt", 32'(bus.hit_cnt), 15);
        chk("sat_frame", 32'(bus.col_frame), 32'b000011);
        repeat (3) begin put(1, 6'b000011, '1, 12'h000, 0); tick(); end
        rst = 0;
        put(0, '0, '1, 12'h000, 1); tick(); tick();
        chk("rstmid_strobe", 32'(bus.col_strobe), 0);
        chk("rstmid_layer", 32'(bus.out_layer), 0);
        rst = 1;
        put(0, '0, '1, 12'h000, 1); tick();
        chk("rstmid_fs_strobe", 32'(bus.col_strobe), 1);
        chk("rstmid_fs_frame", 32'(bus.col_frame), 0);
        chk("rstmid_fs_cnt", 32'(bus.hit_cnt), 0);
        for (int t = 0; t < 3000; t++) begin
            rst = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < NL; i++) rgb[i] = ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom);
            put($urandom_range(0, 7) != 0, 6'($urandom & $urandom),
                ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h3F, 12'($urandom),
                ($urandom_range(0, 29) == 0) || (bus.frame_start && $urandom_range(0, 1) == 1));
            tick();
        end
        rst = 1;
        put(0, '0, '1, 12'h000, 0);
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
